// File: rtl/ipml_fifo_stream_reader.sv
// Read-side drain engine for the generated ipml_fifo_* FIFOs. It absorbs the RAM read
// latency with a credit-controlled skid buffer and presents the words as a valid/ready stream.
module ipml_fifo_stream_reader #(
   parameter int c_DATA_WIDTH = 16,
   parameter int c_RD_LATENCY = 1
) (
   input  logic                    rd_clk,
   input  logic                    rd_rst,
   output logic                    fifo_rd_en,
   input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                    fifo_rd_empty,
   output logic                    m_valid,
   output logic [c_DATA_WIDTH-1:0] m_data,
   input  logic                    m_ready,
   output logic [2:0]              buf_level,
   output logic [31:0]             word_cnt,
   output logic                    ovf_err
);

   // Two spare entries beyond the read latency keep full throughput with a registered issue path.
   localparam int c_BUF_DEPTH = c_RD_LATENCY + 2;
   localparam int c_PTR_W     = $clog2(c_BUF_DEPTH);

   localparam logic [2:0]         c_DEPTH_3 = 3'(c_BUF_DEPTH);
   localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(c_BUF_DEPTH - 1);

   logic [c_DATA_WIDTH-1:0] buf_mem [c_BUF_DEPTH];
   logic [c_PTR_W-1:0]      wr_ptr;
   logic [c_PTR_W-1:0]      rd_ptr;
   logic [2:0]              level;
   logic [2:0]              credit;
   logic [c_RD_LATENCY-1:0] in_flight;

   logic issue;
   logic capture;
   logic pop;
   logic cap_ok;
   logic overflow;

   function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
      return (p == c_PTR_MAX) ? '0 : p + c_PTR_W'(1);
   endfunction

   // Credit covers in-flight reads plus buffered words, so m_ready never reaches the FIFO.
   assign issue      = !fifo_rd_empty && (credit < c_DEPTH_3) && !rd_rst;
   assign fifo_rd_en = issue;

   assign capture  = in_flight[c_RD_LATENCY-1];
   assign pop      = m_valid && m_ready;
   assign overflow = capture && (level == c_DEPTH_3) && !pop;
   assign cap_ok   = capture && !overflow;

   assign m_valid   = (level != 3'd0);
   assign m_data    = buf_mem[rd_ptr];
   assign buf_level = level;

   // The tail of this shift register marks the cycle the FIFO data is valid on fifo_rd_data.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         in_flight <= '0;
      end else begin
         in_flight[0] <= issue;
         for (int i = 1; i < c_RD_LATENCY; i++) begin
            in_flight[i] <= in_flight[i-1];
         end
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         credit <= '0;
      end else if (issue && !pop) begin
         credit <= credit + 3'd1;
      end else if (!issue && pop) begin
         credit <= credit - 3'd1;
      end
   end

   // Storage is cleared on reset so no stale word can surface on m_data afterwards.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         for (int i = 0; i < c_BUF_DEPTH; i++) begin
            buf_mem[i] <= '0;
         end
         wr_ptr <= '0;
      end else if (cap_ok) begin
         buf_mem[wr_ptr] <= fifo_rd_data;
         wr_ptr          <= ptr_inc(wr_ptr);
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         rd_ptr <= '0;
      end else if (pop) begin
         rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         level <= '0;
      end else if (cap_ok && !pop) begin
         level <= level + 3'd1;
      end else if (!cap_ok && pop) begin
         level <= level - 3'd1;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         word_cnt <= '0;
         ovf_err  <= 1'b0;
      end else begin
         if (pop) begin
            word_cnt <= word_cnt + 32'd1;
         end
         if (overflow) begin
            ovf_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ipml_fifo_stream_reader.sv
// Bench for ipml_fifo_stream_reader: one instance per read latency, each fed by a
// behavioural FIFO model, with a scoreboard queue checking every stream word.
module tb_ipml_fifo_stream_reader;

   logic        clk = 1'b0;
   logic        rst1, rst2;
   logic        rdEn1, rdEn2;
   logic [15:0] rdData1, rdData2, d2a;
   logic        empty1, empty2;
   logic        mValid1, mValid2;
   logic [15:0] mData1, mData2;
   logic        mReady1, mReady2;
   logic [2:0]  level1, level2;
   logic [31:0] wordCnt1, wordCnt2;
   logic        ovf1, ovf2;

   bit [15:0]   fifoMem1 [16384];
   bit [15:0]   fifoMem2 [16384];
   int          wrCnt1 = 0, wrCnt2 = 0;
   int          rdCnt1 = 0, rdCnt2 = 0;

   logic [15:0] sb1[$];
   logic [15:0] sb2[$];

   int checks = 0;
   int errors = 0;
   int cycleNum = 0;
   int issued1, popCnt1, firstPop1, lastPop1, firstValid1, firstValid2, pushCycle;
   bit stall1 = 0, stall2 = 0;
   logic [15:0] holdData1, holdData2;

   always #5 clk = ~clk;

   ipml_fifo_stream_reader #(.c_DATA_WIDTH(16), .c_RD_LATENCY(1)) dut1 (
      .rd_clk(clk), .rd_rst(rst1), .fifo_rd_en(rdEn1), .fifo_rd_data(rdData1),
      .fifo_rd_empty(empty1), .m_valid(mValid1), .m_data(mData1), .m_ready(mReady1),
      .buf_level(level1), .word_cnt(wordCnt1), .ovf_err(ovf1));

   ipml_fifo_stream_reader #(.c_DATA_WIDTH(16), .c_RD_LATENCY(2)) dut2 (
      .rd_clk(clk), .rd_rst(rst2), .fifo_rd_en(rdEn2), .fifo_rd_data(rdData2),
      .fifo_rd_empty(empty2), .m_valid(mValid2), .m_data(mData2), .m_ready(mReady2),
      .buf_level(level2), .word_cnt(wordCnt2), .ovf_err(ovf2));

   // FIFO models: latency 1 (no output register) and latency 2 (output register), flushed by reset.
   assign empty1 = (rdCnt1 == wrCnt1);
   assign empty2 = (rdCnt2 == wrCnt2);

   always @(posedge clk) begin
      if (rst1) begin
         rdCnt1  <= wrCnt1;
         rdData1 <= '0;
      end else if (rdEn1) begin
         rdData1 <= fifoMem1[rdCnt1[13:0]];
         rdCnt1  <= rdCnt1 + 1;
      end
   end

   always @(posedge clk) begin
      if (rst2) begin
         rdCnt2  <= wrCnt2;
         d2a     <= '0;
         rdData2 <= '0;
      end else begin
         if (rdEn2) begin
            d2a    <= fifoMem2[rdCnt2[13:0]];
            rdCnt2 <= rdCnt2 + 1;
         end
         rdData2 <= d2a;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int sel, input logic [15:0] w);
      if (sel == 1) begin
         fifoMem1[wrCnt1[13:0]] = w;
         wrCnt1++;
         sb1.push_back(w);
      end else begin
         fifoMem2[wrCnt2[13:0]] = w;
         wrCnt2++;
         sb2.push_back(w);
      end
   endtask

   // Called right after a falling edge with inputs already set for the current cycle.
   task automatic sampleCycle();
      logic [15:0] exp;
      #1;
      cycleNum++;
      if (rdEn1) issued1++;
      if (mValid1 && firstValid1 < 0) firstValid1 = cycleNum;
      if (mValid2 && firstValid2 < 0) firstValid2 = cycleNum;
      if (stall1) begin
         checkOutput("hold_valid1", {31'd0, mValid1}, 32'd1);
         checkOutput("hold_data1", {16'd0, mData1}, {16'd0, holdData1});
      end
      if (stall2) begin
         checkOutput("hold_valid2", {31'd0, mValid2}, 32'd1);
         checkOutput("hold_data2", {16'd0, mData2}, {16'd0, holdData2});
      end
      if (mValid1 && mReady1) begin
         if (sb1.size() != 0) exp = sb1.pop_front(); else exp = 'x;
         checkOutput("sb_data1", {16'd0, mData1}, {16'd0, exp});
         popCnt1++;
         if (firstPop1 < 0) firstPop1 = cycleNum;
         lastPop1 = cycleNum;
      end
      if (mValid2 && mReady2) begin
         if (sb2.size() != 0) exp = sb2.pop_front(); else exp = 'x;
         checkOutput("sb_data2", {16'd0, mData2}, {16'd0, exp});
      end
      checkOutput("level_max1", {31'd0, level1 <= 3'd3}, 32'd1);
      checkOutput("level_max2", {31'd0, level2 <= 3'd4}, 32'd1);
      stall1    = mValid1 && !mReady1;
      stall2    = mValid2 && !mReady2;
      holdData1 = mData1;
      holdData2 = mData2;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         sampleCycle();
         nextCycle();
      end
   endtask

   task automatic drain(input int maxCycles, input bit randReady2);
      int n = 0;
      while ((sb1.size() != 0 || sb2.size() != 0) && n < maxCycles) begin
         if (randReady2) mReady2 = 1'($urandom_range(0, 1));
         sampleCycle();
         nextCycle();
         n++;
      end
      checkOutput("drain_done", sb1.size() + sb2.size(), 32'd0);
   endtask

   task automatic clearStats();
      issued1 = 0; popCnt1 = 0; firstPop1 = -1; lastPop1 = -1;
      firstValid1 = -1; firstValid2 = -1;
   endtask

   initial begin
      rst1 = 1'b1; rst2 = 1'b1; mReady1 = 1'b0; mReady2 = 1'b0;
      clearStats();
      repeat (3) @(negedge clk);
      rst1 = 1'b0; rst2 = 1'b0;

      // Reset state, then idle with both FIFOs empty
      sampleCycle();
      checkOutput("rst_mdata1", {16'd0, mData1}, 32'd0);
      checkOutput("rst_mdata2", {16'd0, mData2}, 32'd0);
      checkOutput("rst_ovf", {30'd0, ovf1, ovf2}, 32'd0);
      nextCycle();
      for (int i = 0; i < 20; i++) begin
         sampleCycle();
         checkOutput("idle_rden", {30'd0, rdEn1, rdEn2}, 32'd0);
         checkOutput("idle_valid", {30'd0, mValid1, mValid2}, 32'd0);
         checkOutput("idle_level", {26'd0, level1, level2}, 32'd0);
         checkOutput("idle_wcnt", wordCnt1 | wordCnt2, 32'd0);
         nextCycle();
      end

      // Streaming at latency 1 with m_ready high
      $display("[TB] streaming 128 words, latency 1");
      clearStats();
      mReady1 = 1'b1;
      for (int i = 0; i < 128; i++) applyStimulus(1, 16'(i));
      pushCycle = cycleNum + 1;
      drain(400, 1'b0);
      checkOutput("stream_first_valid", firstValid1 - pushCycle, 32'd2);
      checkOutput("stream_pops", popCnt1, 32'd128);
      checkOutput("stream_no_gaps", lastPop1 - firstPop1, 32'd127);
      checkOutput("stream_wcnt", wordCnt1, 32'd128);
      checkOutput("stream_valid_end", {31'd0, mValid1}, 32'd0);

      // Backpressure: 10 words waiting, downstream stalled for 15 cycles
      $display("[TB] backpressure, latency 1");
      clearStats();
      mReady1 = 1'b0;
      for (int i = 0; i < 10; i++) applyStimulus(1, 16'(i));
      runCycles(15);
      checkOutput("bp_issued", issued1, 32'd3);
      checkOutput("bp_level", {29'd0, level1}, 32'd3);
      checkOutput("bp_valid", {31'd0, mValid1}, 32'd1);
      checkOutput("bp_mdata", {16'd0, mData1}, 32'd0);
      mReady1 = 1'b1;
      drain(100, 1'b0);
      checkOutput("bp_pops", popCnt1, 32'd10);
      checkOutput("bp_no_gaps", lastPop1 - firstPop1, 32'd9);
      checkOutput("bp_wcnt", wordCnt1, 32'd138);

      // Random backpressure at latency 2 over 10000 words
      $display("[TB] random m_ready, latency 2, 10000 words");
      clearStats();
      for (int i = 0; i < 10000; i++) applyStimulus(2, 16'($urandom));
      pushCycle = cycleNum + 1;
      drain(60000, 1'b1);
      mReady2 = 1'b0;
      checkOutput("rand_first_valid", firstValid2 - pushCycle, 32'd3);
      checkOutput("rand_wcnt", wordCnt2, 32'd10000);
      checkOutput("rand_ovf", {31'd0, ovf2}, 32'd0);

      // Reset with two reads in flight at latency 2
      $display("[TB] reset mid-stream, latency 2");
      for (int i = 0; i < 6; i++) applyStimulus(2, 16'hC000 | 16'(i));
      sampleCycle();
      checkOutput("mid_rden_t0", {31'd0, rdEn2}, 32'd1);
      nextCycle();
      sampleCycle();
      checkOutput("mid_rden_t1", {31'd0, rdEn2}, 32'd1);
      nextCycle();
      rst2 = 1'b1;
      sb2.delete();
      sampleCycle();
      checkOutput("mid_rden_rst", {31'd0, rdEn2}, 32'd0);
      nextCycle();
      rst2 = 1'b0;
      stall2 = 1'b0;
      sampleCycle();
      checkOutput("mid_valid", {31'd0, mValid2}, 32'd0);
      checkOutput("mid_level", {29'd0, level2}, 32'd0);
      checkOutput("mid_wcnt", wordCnt2, 32'd0);
      checkOutput("mid_mdata", {16'd0, mData2}, 32'd0);
      checkOutput("mid_rden", {31'd0, rdEn2}, 32'd0);
      nextCycle();
      runCycles(5);
      checkOutput("mid_no_stale", {31'd0, mValid2}, 32'd0);
      mReady2 = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(2, 16'hA5A0 | 16'(i));
      drain(50, 1'b0);
      checkOutput("mid_wcnt_after", wordCnt2, 32'd3);

      // Word counter wrap at latency 1
      $display("[TB] word counter wrap");
      mReady1 = 1'b0;
      force dut1.word_cnt = 32'hFFFF_FFFE;
      nextCycle();
      release dut1.word_cnt;
      sampleCycle();
      checkOutput("wrap_preload", wordCnt1, 32'hFFFF_FFFE);
      nextCycle();
      mReady1 = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1, 16'h5A00 | 16'(i));
      drain(50, 1'b0);
      checkOutput("wrap_wcnt", wordCnt1, 32'h0000_0001);
      checkOutput("final_ovf1", {31'd0, ovf1}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ipml_fifo_stream_reader.md
# ipml_fifo_stream_reader

Read-side drain engine for the generated `ipml_fifo_*` FIFOs used in the QSGMII test path. It drives the FIFO read port (`rd_en` / `rd_data` / `rd_empty`) and absorbs the RAM's fixed read latency. It presents the data as a valid/ready stream with full one-word-per-cycle throughput and no combinational path from `m_ready` to the FIFO. It sits between the FIFO read side and the packet checker / MAC transmit logic, in the FIFO's read clock domain.

## Interface
Parameters:
- `c_DATA_WIDTH`, 16, width of FIFO read data and stream data.
- `c_RD_LATENCY`, 1, FIFO read latency in cycles.
  - 1 when the FIFO is built with `c_OUTPUT_REG`=0.
  - 2 when `c_OUTPUT_REG`=1.
  - Any other value is illegal.
- `c_BUF_DEPTH`, derived, `c_RD_LATENCY`+2, number of skid-buffer entries. Not user-settable.

Ports (clock and reset first):
- `rd_clk`  in  1  single clock; all logic is on the rising edge.
- `rd_rst`  in  1  reset, synchronous, active-high.
- `fifo_rd_en`  out  1  read enable to the FIFO; also drives its read clock enable.
- `fifo_rd_data`  in  `c_DATA_WIDTH`  FIFO read data, valid `c_RD_LATENCY` cycles after `fifo_rd_en`.
- `fifo_rd_empty`  in  1  FIFO empty flag.
- `m_valid`  out  1  stream word valid.
- `m_data`  out  `c_DATA_WIDTH`  stream data.
- `m_ready`  in  1  downstream accept.
- `buf_level`  out  3  skid-buffer occupancy, range 0..`c_BUF_DEPTH`.
- `word_cnt`  out  32  number of words accepted on the stream.
- `ovf_err`  out  1  sticky; set if returning data finds the buffer full.

## Operation
- Credit counter `credit` = in-flight reads + `buf_level`.
  - Increments on issue.
  - Decrements on stream pop (`m_valid & m_ready`).
  - Issue and pop in the same cycle leave it unchanged.
- `fifo_rd_en` = `!fifo_rd_empty & (credit < c_BUF_DEPTH) & !rd_rst`.
  - Depends only on registered state and `fifo_rd_empty`, never on `m_ready`.
- In-flight tracker: a `c_RD_LATENCY`-deep valid shift register fed by `fifo_rd_en`.
  - Its tail marks the cycle in which `fifo_rd_data` is captured into the buffer.
- Skid buffer: circular, `c_BUF_DEPTH` entries.
  - Write pointer advances on capture; read pointer advances on pop.
  - Pointers wrap modulo `c_BUF_DEPTH`.
  - Capture and pop in the same cycle are legal at any occupancy, including full and empty.
- Stream output:
  - `m_valid` = `buf_level != 0`.
  - `m_data` = entry at the read pointer.
  - While `m_valid & !m_ready`, `m_data` holds stable.
  - `m_valid` never drops without a pop.
- `word_cnt` increments by 1 per pop and wraps from 0xFFFFFFFF to 0.
- `ovf_err` sets if a capture occurs while `buf_level==c_BUF_DEPTH` with no same-cycle pop. This is unreachable by design; it serves as a bench assertion hook. It clears only on reset.

## Timing
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `buf_level`=0, `word_cnt`=0, `ovf_err`=0; pointers, credit and tracker all 0.
- Reset mid-operation:
  - All in-flight reads are discarded.
  - `fifo_rd_en` is 0 in every cycle `rd_rst` is high.
  - The FIFO itself is reset by the same `rd_rst`, so no data is lost inconsistently.
- Latency: with `fifo_rd_en` high in cycle T, the word is captured at the end of cycle T+`c_RD_LATENCY` and `m_valid` is high in T+`c_RD_LATENCY`+1.
  - First word after `fifo_rd_empty` falls: `m_valid` follows 2 cycles later (`c_RD_LATENCY`=1) or 3 cycles later (`c_RD_LATENCY`=2).
- Throughput: with `m_ready` held high and the FIFO non-empty, `fifo_rd_en` and pops occur every cycle (100%).
- Backpressure: with `m_ready` low, issue stops once credit reaches `c_BUF_DEPTH`. All in-flight data still fits in the buffer.
- Empty: when `fifo_rd_empty`=1, no read is issued; already-issued words still drain to the stream.

## Test plan
- Reset then idle:
  - Stimulus: `fifo_rd_empty`=1 for 20 cycles.
  - Required: `fifo_rd_en`=0, `m_valid`=0, `buf_level`=0, `word_cnt`=0 throughout.
- Streaming, `c_RD_LATENCY`=1, `m_ready`=1:
  - Stimulus: 128 words 0x0000..0x007F written, then read.
  - Required: 128 consecutive-cycle pops in order; first `m_valid` 2 cycles after empty deasserts; `word_cnt`=128.
- Backpressure:
  - Stimulus: FIFO holds 10 words, `m_ready`=0 for 15 cycles.
  - Required: exactly 3 reads issued (`c_RD_LATENCY`=1), `buf_level`=3, `m_data`=0x0000 stable.
  - Then `m_ready`=1: remaining words delivered in order, no gaps.
- Random `m_ready` (50%) with `c_RD_LATENCY`=2 over 10000 words:
  - Required: scoreboard match on every word; `ovf_err`=0; `buf_level` never exceeds 4.
- Reset mid-stream:
  - Stimulus: assert `rd_rst` for 1 cycle while 2 reads are in flight.
  - Required: next cycle all outputs at reset values; no stale word appears on `m_data` afterwards.
- Counter wrap:
  - Stimulus: force `word_cnt` to 0xFFFFFFFE, then pop 3 words.
  - Required: `word_cnt` reads 0x00000001.
